// File: rtl/mem_pkg.sv
// Shared load/store types and the lane extract/merge helpers used by lsu_ctrl
// and later cache logic.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_LOAD,
    ST_RMW_RD,
    ST_WRITE,
    ST_RESP
  } lsu_state_e;

  // Little-endian lane select with optional sign extension.
  function automatic logic [31:0] mem_extract(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input lsu_size_e   size,
                                              input logic        sgn);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: begin
        if (sgn) r = 32'(b);
        else     r = {24'h0, b};
      end
      SZ_HALF: begin
        if (sgn) r = 32'(h);
        else     r = {16'h0, h};
      end
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] mem_merge(input logic [31:0] old,
                                            input logic [31:0] wdata,
                                            input logic [1:0]  off,
                                            input lsu_size_e   size);
    logic [31:0] r;
    r = old;
    case (size)
      SZ_BYTE: begin
        case (off)
          2'd0:    r[7:0]   = wdata[7:0];
          2'd1:    r[15:8]  = wdata[7:0];
          2'd2:    r[23:16] = wdata[7:0];
          default: r[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (off[1]) r[31:16] = wdata[15:0];
        else        r[15:0]  = wdata[15:0];
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store initiator: checks alignment/range, extends
// sub-word loads and performs sub-word stores as read-modify-write.
module lsu_ctrl
  import mem_pkg::*;
#(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_a,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [31:0] ADDR_LIM = 32'(4 * MEM_WORDS);

  lsu_state_e  state;
  logic        lat_we;
  logic [1:0]  lat_size;
  logic        lat_signed;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        access_err;

  assign mem_a = {lat_addr[31:2], 2'b00};

  always_comb begin
    access_err = 1'b0;
    case (lat_size)
      SZ_BYTE: access_err = 1'b0;
      SZ_HALF: access_err = lat_addr[0];
      SZ_WORD: access_err = |lat_addr[1:0];
      default: access_err = 1'b1;
    endcase
    if (lat_addr >= ADDR_LIM) access_err = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_we     <= 1'b0;
      mem_wd     <= '0;
      lat_we     <= 1'b0;
      lat_size   <= '0;
      lat_signed <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else begin
      resp_valid <= 1'b0;
      mem_we     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_we     <= req_we;
            lat_size   <= req_size;
            lat_signed <= req_signed;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
            req_ready  <= 1'b0;
            state      <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (access_err) begin
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end else if (!lat_we) begin
            state <= ST_LOAD;
          end else if (lat_size == SZ_WORD) begin
            mem_wd <= lat_wdata;
            mem_we <= 1'b1;
            state  <= ST_WRITE;
          end else begin
            state <= ST_RMW_RD;
          end
        end
        ST_LOAD: begin
          resp_rdata <= mem_extract(mem_rd, lat_addr[1:0], lsu_size_e'(lat_size), lat_signed);
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        // mem_wd doubles as the merge buffer so it is stable for the WRITE cycle.
        ST_RMW_RD: begin
          mem_wd <= mem_merge(mem_rd, lat_wdata, lat_addr[1:0], lsu_size_e'(lat_size));
          mem_we <= 1'b1;
          state  <= ST_WRITE;
        end
        ST_WRITE: begin
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          resp_err  <= 1'b0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store initiator between the pipeline's memory stage and the word-addressed data memory.
- The data memory has a combinational read port and a write port that commits on the clock edge.
- Accepts one byte, halfword or word request at a time over a valid/ready handshake.
- Performs sub-word stores as read-modify-write, sign- or zero-extends loads, and flags misaligned or out-of-range accesses without touching memory.

Parameters:
- MEM_WORDS, 64, number of 32-bit words in the attached data memory; valid byte addresses are 0 to 4*MEM_WORDS-1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal.
- req_signed  in  1  sign-extend a sub-word load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the sub-word value is in the low bits.
- resp_valid  out  1  one-cycle response strobe.
- resp_err  out  1  qualified by resp_valid: the access was rejected.
- resp_rdata  out  32  load result, qualified by resp_valid with req_we=0 and no error.
- mem_a  out  32  word-aligned byte address to the data memory.
- mem_we  out  1  memory write enable.
- mem_wd  out  32  memory write data.
- mem_rd  in  32  combinational memory read data for mem_a.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE; req_ready = 1.
  - resp_valid, resp_err, mem_we = 0.
  - resp_rdata, mem_a, mem_wd = 0.
  - All latched request fields = 0.
- mem_a is always {lat_addr[31:2], 2'b00}.
- mem_we is asserted only in state WRITE.
- FSM states: IDLE, CHECK, LOAD, RMW_RD, WRITE, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch we, size, signed, addr and wdata, then go to CHECK.
  - Request inputs are ignored in every other state.
- CHECK: error if any of the following holds:
  - size = 3;
  - halfword with addr[0] = 1;
  - word with addr[1:0] != 0;
  - addr >= 4*MEM_WORDS.
  On error, set resp_err = 1 and go to RESP with no memory access. Otherwise:
  - load → LOAD;
  - word store → WRITE;
  - byte or halfword store → RMW_RD.
- LOAD:
  - Lane offset off = addr[1:0]; little-endian.
  - Byte result: mem_rd[8*off+7 : 8*off].
  - Halfword result: mem_rd[16*addr[1]+15 : 16*addr[1]].
  - The result is extended by req_signed and registered into resp_rdata.
  - Next state RESP.
- RMW_RD:
  - Register mem_rd into a merge buffer.
  - Replace the addressed byte or halfword lane with the low bits of wdata; other lanes are unchanged.
  - Next state WRITE.
- WRITE:
  - mem_we = 1 for exactly one cycle.
  - mem_wd = wdata for a word store, or the merge buffer for a sub-word store.
  - Next state RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle.
  - resp_err and resp_rdata are held stable from the previous state.
  - Next state IDLE; resp_err is cleared when IDLE is entered.
- Latency, counted from the accept edge to the resp_valid cycle:
  - load: 3 cycles;
  - word store: 3 cycles;
  - sub-word store: 4 cycles;
  - error: 2 cycles.
- At most one request is outstanding.
- req_ready is low from the accept edge until IDLE is re-entered.
- A back-to-back request is therefore accepted on the cycle after RESP.
- resp_rdata on a store response is don't-care but must retain its last load value; it is not cleared.
- Reset mid-operation:
  - The FSM returns to IDLE immediately and the request is discarded.
  - No partial write occurs if reset falls before the WRITE edge.
  - A WRITE already committed stays committed.
- The response side has no back-pressure; the consumer must sample resp_valid.

Decomposition:
- Shared package mem_pkg holds:
  - enum lsu_size_e (SZ_BYTE, SZ_HALF, SZ_WORD);
  - enum lsu_state_e;
  - function mem_extract(word, off, size, signed);
  - function mem_merge(old, wdata, off, size).
- Both functions are combinational so they can be reused by later cache logic.
- No sub-module is needed.
- The bench instantiates the existing data memory, with MEM_WORDS matching its depth, as the responder.

Test Plan:
- Word round trip: store 0xDEADBEEF at addr 0x10, then word load at 0x10 → resp_rdata = 0xDEADBEEF, resp_err = 0; store takes 3 cycles and mem_we is high exactly once.
- Byte store by RMW:
  - Preload word 0x11223344 at 0x20.
  - Byte store of 0xAA at 0x22 → memory word = 0x11AA3344; response after 4 cycles.
  - Signed byte load at 0x22 → 0xFFFFFFAA; unsigned byte load → 0x000000AA.
- Halfword: halfword store 0x8001 at 0x32 over 0 → word = 0x80010000; signed halfword load at 0x32 → 0xFFFF8001.
- Misaligned and illegal accesses:
  - word at 0x06, halfword at 0x03, size = 3, addr 0x100 with MEM_WORDS = 64.
  - Each gives resp_err = 1 after 2 cycles, mem_we never asserted, and memory unchanged.
- Handshake: req_valid held high continuously with 3 different loads → req_ready low between accepts; each request is accepted on the cycle after its predecessor's RESP; responses arrive in order.
- Reset in RMW_RD during a byte store → outputs reach their reset values immediately; memory word unchanged; the next request completes normally.
